// File: rtl/mem_stage_unit_pkg.sv
// rtl/mem_stage_unit_pkg.sv - shared ISA widths, memory base address and MEM-stage FSM encoding
//
// Purpose: common definitions imported by the memory-access stage and its data memory.
//   LEN_REGISTER     : architectural register width in bits
//   LEN_REG_ADDRESS  : register-file address width in bits
//   MEM_BASE_ADDRESS : default byte address mapped to data-memory word 0
//   mem_state_t      : access FSM states (IDLE waits for a request, BUSY counts latency)
package mem_stage_unit_pkg;

    localparam int LEN_REGISTER     = 32;
    localparam int LEN_REG_ADDRESS  = 4;
    localparam int MEM_BASE_ADDRESS = 1024;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_stage_unit_data_memory.sv
// rtl/mem_stage_unit_data_memory.sv - word-addressed data memory, synchronous write, asynchronous read
//
// Purpose: DEPTH x LEN_REGISTER storage array for the memory stage. Not reset, so
// contents survive a pipeline reset.
// Ports:
//   clk      : write clock
//   wr_en    : write enable, commits wr_data at the rising edge
//   wr_index : word index written
//   wr_data  : word written
//   rd_index : word index read (combinational)
//   rd_data  : word at rd_index
module data_memory
    import mem_stage_unit_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [IW-1:0]           wr_index,
    input  logic [LEN_REGISTER-1:0] wr_data,
    input  logic [IW-1:0]           rd_index,
    output logic [LEN_REGISTER-1:0] rd_data
);

    logic [LEN_REGISTER-1:0] mem_array [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[wr_index] <= wr_data;
        end
    end

    assign rd_data = mem_array[rd_index];

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - ARM pipeline memory-access stage with multi-cycle data memory and MEM/WB register
//
// Purpose: performs loads/stores for the instruction held by EX, stalls upstream via
// mem_ready while an access takes MEM_LATENCY cycles, and registers results for WB.
// Optional feature macro: MEM_ALIGN_CHECK_EN (alignment/range checking with sticky mem_err).
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   mem_read_in, mem_write_in     : load / store request (both set = store)
//   wb_enable_in, dest_reg_in     : write-back control and destination from EX
//   alu_result_in, store_data_in  : byte address or ALU result; store data
//   mem_ready                     : 1 = EX outputs accepted this cycle, 0 = freeze upstream
//   wb_enable_out, mem_read_out   : registered controls (bubble while stalled)
//   dest_reg_out, alu_result_out  : registered destination and ALU result
//   mem_data_out                  : registered load data
//   mem_err                       : sticky illegal-access flag (0 without the check)
module mem_stage_unit
    import mem_stage_unit_pkg::*;
#(
    parameter int MEM_DEPTH    = 64,
    parameter int MEM_LATENCY  = 2,
    parameter int BASE_ADDRESS = MEM_BASE_ADDRESS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read_in,
    input  logic                       mem_write_in,
    input  logic                       wb_enable_in,
    input  logic [LEN_REG_ADDRESS-1:0] dest_reg_in,
    input  logic [LEN_REGISTER-1:0]    alu_result_in,
    input  logic [LEN_REGISTER-1:0]    store_data_in,
    output logic                       mem_ready,
    output logic                       wb_enable_out,
    output logic                       mem_read_out,
    output logic [LEN_REG_ADDRESS-1:0] dest_reg_out,
    output logic [LEN_REGISTER-1:0]    alu_result_out,
    output logic [LEN_REGISTER-1:0]    mem_data_out,
    output logic                       mem_err
);

    localparam int IW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0]           CNT_LAST = CW'(MEM_LATENCY - 1);
    localparam logic [LEN_REGISTER-1:0] BASE     = LEN_REGISTER'(BASE_ADDRESS);
    localparam bit                      SINGLE   = (MEM_LATENCY == 1);

    mem_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic          req;
    logic          is_store;
    logic          is_load;
    logic          access_done;
    logic          access_legal;
    logic          mem_we;
    logic [IW+1:0] offset_lo;
    logic [IW-1:0] word_index;
    logic [LEN_REGISTER-1:0] rd_data;
    logic [LEN_REGISTER-1:0] load_data;

    assign req      = mem_read_in | mem_write_in;
    assign is_store = mem_write_in;
    assign is_load  = mem_read_in & ~mem_write_in;

    // Only the low bits of the offset are needed for the (wrapping) index; the
    // subtraction of the low bits alone gives the same result as the full one.
    assign offset_lo  = alu_result_in[IW+1:0] - BASE[IW+1:0];
    assign word_index = offset_lo[IW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    // Aligned and at/above the base, so the byte offset bound is equivalent to
    // the untruncated word index being inside the array.
    assign access_legal = (alu_result_in[1:0] == 2'b00) &&
                          (alu_result_in >= BASE) &&
                          ((alu_result_in - BASE) < LEN_REGISTER'(MEM_DEPTH * 4));
`else
    assign access_legal = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mem_ready   = 1'b1;
        access_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (SINGLE) begin
                        access_done = 1'b1;
                    end else begin
                        mem_ready = 1'b0;
                        state_nxt = ST_BUSY;
                        cnt_nxt   = CW'(1);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_LAST) begin
                    access_done = 1'b1;
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                end else begin
                    mem_ready = 1'b0;
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // rst gates the write so a store in flight when reset arrives never commits.
    assign mem_we    = access_done & is_store & access_legal & ~rst;
    assign load_data = access_legal ? rd_data : '0;

    data_memory #(
        .DEPTH (MEM_DEPTH),
        .IW    (IW)
    ) u_data_memory (
        .clk      (clk),
        .wr_en    (mem_we),
        .wr_index (word_index),
        .wr_data  (store_data_in),
        .rd_index (word_index),
        .rd_data  (rd_data)
    );

    // MEM/WB register: loads the instruction when accepted, otherwise a bubble
    // (controls cleared, payload held). WB side is never frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_enable_out  <= 1'b0;
            mem_read_out   <= 1'b0;
            dest_reg_out   <= '0;
            alu_result_out <= '0;
            mem_data_out   <= '0;
        end else if (mem_ready) begin
            wb_enable_out  <= wb_enable_in;
            mem_read_out   <= is_load;
            dest_reg_out   <= dest_reg_in;
            alu_result_out <= alu_result_in;
            if (access_done && is_load) begin
                mem_data_out <= load_data;
            end
        end else begin
            wb_enable_out <= 1'b0;
            mem_read_out  <= 1'b0;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else if (access_done && !access_legal) begin
            mem_err <= 1'b1;
        end
    end
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - self-checking bench for mem_stage_unit at latency 2 and 4
module tb_mem_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_rd, in_wr, in_wbe;
    logic [3:0]  in_dest;
    logic [31:0] in_alu, in_sd;

    logic        ready2, wbe2, mrd2, err2;
    logic [3:0]  dest2;
    logic [31:0] alu2, data2;
    logic        ready4, wbe4, mrd4, err4;
    logic [3:0]  dest4;
    logic [31:0] alu4, data4;

    logic [31:0] model [2][64];
    logic [31:0] exp_data [2];
    logic        exp_err [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    mem_stage_unit #(.MEM_DEPTH(64), .MEM_LATENCY(2), .BASE_ADDRESS(1024)) dut2 (
        .clk(clk), .rst(rst),
        .mem_read_in(in_rd & ~sel), .mem_write_in(in_wr & ~sel), .wb_enable_in(in_wbe & ~sel),
        .dest_reg_in(in_dest), .alu_result_in(in_alu), .store_data_in(in_sd),
        .mem_ready(ready2), .wb_enable_out(wbe2), .mem_read_out(mrd2),
        .dest_reg_out(dest2), .alu_result_out(alu2), .mem_data_out(data2), .mem_err(err2)
    );

    mem_stage_unit #(.MEM_DEPTH(64), .MEM_LATENCY(4), .BASE_ADDRESS(1024)) dut4 (
        .clk(clk), .rst(rst),
        .mem_read_in(in_rd & sel), .mem_write_in(in_wr & sel), .wb_enable_in(in_wbe & sel),
        .dest_reg_in(in_dest), .alu_result_in(in_alu), .store_data_in(in_sd),
        .mem_ready(ready4), .wb_enable_out(wbe4), .mem_read_out(mrd4),
        .dest_reg_out(dest4), .alu_result_out(alu4), .mem_data_out(data4), .mem_err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] word_of(input logic [31:0] addr);
        logic [31:0] w;
        w = ((addr - 32'd1024) >> 2) % 64;
        return w[5:0];
    endfunction

    function automatic logic legal_of(input logic [31:0] addr);
        return (addr % 4 == 0) && (addr >= 32'd1024) && (((addr - 32'd1024) / 4) < 64);
    endfunction

    // Present one instruction, wait for acceptance, then check the MEM/WB outputs.
    task automatic op(input logic s, input logic rd, input logic wr, input logic wbe,
                      input logic [3:0] dest, input logic [31:0] addr, input logic [31:0] sd);
        int         stalls;
        int         lat;
        logic       ok;
        logic [5:0] ix;
        sel = s; in_rd = rd; in_wr = wr; in_wbe = wbe;
        in_dest = dest; in_alu = addr; in_sd = sd;
        lat = s ? 4 : 2;
        ix  = word_of(addr);
        ok  = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
        ok = legal_of(addr);
`endif
        stalls = 0;
        #1;
        while (!(s ? ready4 : ready2) && stalls < 10) begin
            @(posedge clk); #1;
            chk("bubble_wb_enable", s ? wbe4 : wbe2, 32'd0);
            chk("bubble_mem_read", s ? mrd4 : mrd2, 32'd0);
            stalls++;
            #1;
        end
        chk("stall_cycles", stalls, (rd | wr) ? lat - 1 : 0);
        @(posedge clk); #1;
        if (wr && ok) model[s][ix] = sd;
        if (rd && !wr) exp_data[s] = ok ? model[s][ix] : 32'd0;
        if ((rd | wr) && !ok) exp_err[s] = 1'b1;
        chk("wb_enable_out", s ? wbe4 : wbe2, wbe);
        chk("mem_read_out", s ? mrd4 : mrd2, rd & ~wr);
        chk("dest_reg_out", s ? dest4 : dest2, dest);
        chk("alu_result_out", s ? alu4 : alu2, addr);
        chk("mem_data_out", s ? data4 : data2, exp_data[s]);
        chk("mem_err", s ? err4 : err2, exp_err[s]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sel = 1'b0;
        in_rd = 0; in_wr = 0; in_wbe = 0; in_dest = 0; in_alu = 0; in_sd = 0;
        exp_data[0] = 0; exp_data[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_ready", ready2, 32'd1);
        chk("rst_wb_enable", wbe2, 32'd0);
        chk("rst_mem_read", mrd2, 32'd0);
        chk("rst_dest", dest2, 32'd0);
        chk("rst_alu", alu2, 32'd0);
        chk("rst_data", data2, 32'd0);
        chk("rst_err", err2, 32'd0);
        chk("rst_data_l4", data4, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", ready2, 32'd1);

        // ALU pass-through: no stall, visible next cycle
        op(0, 0, 0, 1, 4'd3, 32'h55, 32'h0);

        // fill the latency-2 memory so every later load has a known reference
        for (int i = 0; i < 64; i++) op(0, 0, 1, 0, 4'd0, 32'd1024 + 4 * i, $urandom);

        // store then load, back to back
        op(0, 0, 1, 0, 4'd0, 32'd1028, 32'hDEADBEEF);
        op(0, 1, 0, 1, 4'd5, 32'd1028, 32'h0);
        chk("store_load_data", data2, 32'hDEADBEEF);

        // latency 4
        op(1, 0, 1, 0, 4'd0, 32'd1024, 32'hA5A50F0F);
        op(1, 1, 0, 1, 4'd7, 32'd1024, 32'h0);
        chk("l4_load_data", data4, 32'hA5A50F0F);

        // reset during the BUSY cycle of a store
        sel = 0; in_rd = 0; in_wr = 1; in_wbe = 0; in_dest = 0; in_alu = 32'd1032; in_sd = 32'h1234;
        #1;
        chk("mid_store_stall", ready2, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        in_wr = 0;
        #1;
        chk("mid_rst_ready", ready2, 32'd1);
        chk("mid_rst_data", data2, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_data[0] = 0; exp_data[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
        op(0, 1, 0, 1, 4'd2, 32'd1032, 32'h0);

        // misaligned store and below-base load
        op(0, 0, 1, 0, 4'd0, 32'd1026, 32'hCAFEF00D);
        op(0, 1, 0, 1, 4'd1, 32'd1000, 32'h0);
        op(0, 0, 0, 1, 4'd9, 32'h77, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("illegal_err_sticky", err2, 32'd1);
`endif

        // randomized mix including wrapped / unaligned addresses and read+write
        for (int n = 0; n < 60; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            a = ($urandom_range(0, 5) == 0) ? $urandom : 32'd1024 + 4 * $urandom_range(0, 63);
            case (kind)
                0:       op(0, 0, 0, 1'($urandom), 4'($urandom), $urandom, $urandom);
                1:       op(0, 0, 1, 0, 4'($urandom), a, $urandom);
                2:       op(0, 1, 0, 1, 4'($urandom), a, $urandom);
                default: op(0, 1, 1, 0, 4'($urandom), a, $urandom);
            endcase
        end

        // final reset clears the sticky flag
        in_rd = 0; in_wr = 0; in_wbe = 0;
        rst = 1'b1;
        #1;
        chk("final_rst_err", err2, 32'd0);
        chk("final_rst_ready", ready2, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
